// File: rtl/minmax_tracker_16_pkg.sv
// Shared definitions for the min/max frame tracker: FSM encoding and the
// comparator cascade seed.
package minmax_tracker_16_pkg;

    typedef enum logic [1:0] {
        ST_FIRST = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    // Cascade input {G, E, L}: an isolated comparator starts from "equal".
    localparam logic [2:0] CASCADE_SEED = 3'b010;

endpackage

// File: rtl/minmax_tracker_16_comparator.sv
// 16-bit unsigned magnitude comparator stage with G/E/L cascade inputs.
// A local decision (A>B or A<B) overrides the cascade; equality passes it on.
module comparator_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        g_in,
    input  logic        e_in,
    input  logic        l_in,
    output logic        g_out,
    output logic        e_out,
    output logic        l_out
);

    // Local magnitude decision, falling back to the cascade on equality.
    always_comb begin
        g_out = g_in;
        e_out = e_in;
        l_out = l_in;
        if (a > b) begin
            g_out = 1'b1;
            e_out = 1'b0;
            l_out = 1'b0;
        end else if (a < b) begin
            g_out = 1'b0;
            e_out = 1'b0;
            l_out = 1'b1;
        end
    end

endmodule

// File: rtl/minmax_tracker_16.sv
// Tracks running max/min (with first-occurrence index) and length of a
// sample frame, then presents one registered result word downstream.
//
//   state    | meaning
//   ---------+------------------------------------------------
//   ST_FIRST | waiting for the first sample of a frame
//   ST_ACCUM | frame in progress, one sample per cycle
//   ST_HOLD  | result word held until out_ready
module minmax_tracker_16
    import minmax_tracker_16_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_max,
    output logic [15:0]      out_min,
    output logic [CNT_W-1:0] out_max_idx,
    output logic [CNT_W-1:0] out_min_idx,
    output logic [CNT_W:0]   out_count,
    output logic             out_ovf
);

    // Count value at which the frame has filled every trackable index.
    localparam logic [CNT_W:0] COUNT_SAT = {1'b1, {CNT_W{1'b0}}};

    state_e             state_q, state_d;
    logic [15:0]        max_q, max_d;
    logic [15:0]        min_q, min_d;
    logic [CNT_W-1:0]   max_idx_q, max_idx_d;
    logic [CNT_W-1:0]   min_idx_q, min_idx_d;
    logic [CNT_W:0]     count_q, count_d;
    logic               ovf_q, ovf_d;

    logic               accept;
    logic               count_sat;
    logic               new_max;
    logic               new_min;
    logic [1:0]         max_cmp_unused;
    logic [1:0]         min_cmp_unused;

    comparator_16 u_cmp_max (
        .a     (in_data),
        .b     (max_q),
        .g_in  (CASCADE_SEED[2]),
        .e_in  (CASCADE_SEED[1]),
        .l_in  (CASCADE_SEED[0]),
        .g_out (new_max),
        .e_out (max_cmp_unused[1]),
        .l_out (max_cmp_unused[0])
    );

    comparator_16 u_cmp_min (
        .a     (in_data),
        .b     (min_q),
        .g_in  (CASCADE_SEED[2]),
        .e_in  (CASCADE_SEED[1]),
        .l_in  (CASCADE_SEED[0]),
        .g_out (min_cmp_unused[1]),
        .e_out (min_cmp_unused[0]),
        .l_out (new_min)
    );

    // in_ready is a pure function of state so it never depends on out_ready.
    assign in_ready    = (state_q != ST_HOLD);
    assign accept      = in_valid && in_ready;
    assign count_sat   = (count_q == COUNT_SAT);

    assign out_valid   = (state_q == ST_HOLD);
    assign out_max     = max_q;
    assign out_min     = min_q;
    assign out_max_idx = max_idx_q;
    assign out_min_idx = min_idx_q;
    assign out_count   = count_q;
    assign out_ovf     = ovf_q;

    // Next-state and datapath update; ties never update so the earliest index wins.
    always_comb begin
        state_d   = state_q;
        max_d     = max_q;
        min_d     = min_q;
        max_idx_d = max_idx_q;
        min_idx_d = min_idx_q;
        count_d   = count_q;
        ovf_d     = ovf_q;

        case (state_q)
            ST_FIRST: begin
                if (accept) begin
                    max_d     = in_data;
                    min_d     = in_data;
                    max_idx_d = '0;
                    min_idx_d = '0;
                    count_d   = {{CNT_W{1'b0}}, 1'b1};
                    ovf_d     = 1'b0;
                    state_d   = in_last ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    if (new_max) begin
                        max_d = in_data;
                        if (!count_sat) begin
                            max_idx_d = count_q[CNT_W-1:0];
                        end
                    end
                    if (new_min) begin
                        min_d = in_data;
                        if (!count_sat) begin
                            min_idx_d = count_q[CNT_W-1:0];
                        end
                    end
                    if (count_sat) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                    if (in_last) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_FIRST;
                end
            end
            default: begin
                state_d = ST_FIRST;
            end
        endcase
    end

    // State and datapath registers; reset discards any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FIRST;
            max_q     <= '0;
            min_q     <= '0;
            max_idx_q <= '0;
            min_idx_q <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            max_q     <= max_d;
            min_q     <= min_d;
            max_idx_q <= max_idx_d;
            min_idx_q <= min_idx_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_minmax_tracker_16.sv
// Scoreboard bench for minmax_tracker_16: stimulus pushes expected result
// words, per-instance monitors compare whenever a result is presented.
module tb_minmax_tracker_16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: CNT_W = 8
    logic        in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
    logic [15:0] in_data, out_max, out_min;
    logic [7:0]  out_max_idx, out_min_idx;
    logic [8:0]  out_count;

    // Instance B: CNT_W = 2, used for saturation/overflow
    logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_ovf;
    logic [15:0] b_in_data, b_out_max, b_out_min;
    logic [1:0]  b_out_max_idx, b_out_min_idx;
    logic [2:0]  b_out_count;

    minmax_tracker_16 #(.CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_max(out_max), .out_min(out_min),
        .out_max_idx(out_max_idx), .out_min_idx(out_min_idx),
        .out_count(out_count), .out_ovf(out_ovf)
    );

    minmax_tracker_16 #(.CNT_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_max(b_out_max), .out_min(b_out_min),
        .out_max_idx(b_out_max_idx), .out_min_idx(b_out_min_idx),
        .out_count(b_out_count), .out_ovf(b_out_ovf)
    );

    typedef struct {
        int mx;
        int mn;
        int mxi;
        int mni;
        int cnt;
        int ovf;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int mx, input int mn, input int mxi,
                                input int mni, input int cnt, input int ovf);
        exp_t e;
        e.mx = mx; e.mn = mn; e.mxi = mxi; e.mni = mni; e.cnt = cnt; e.ovf = ovf;
        return e;
    endfunction

    // Monitor A: checks every presented cycle (stability), pops on handshake.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst_n && out_valid) begin
            cmp("a_in_ready_in_hold", {31'd0, in_ready}, 32'd0);
            if (q_a.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL a_unexpected_result: got max %0d, expected no result", out_max);
            end else begin
                e = q_a[0];
                cmp("a_max",     {16'd0, out_max},     e.mx);
                cmp("a_min",     {16'd0, out_min},     e.mn);
                cmp("a_max_idx", {24'd0, out_max_idx}, e.mxi);
                cmp("a_min_idx", {24'd0, out_min_idx}, e.mni);
                cmp("a_count",   {23'd0, out_count},   e.cnt);
                cmp("a_ovf",     {31'd0, out_ovf},     e.ovf);
                if (out_ready) void'(q_a.pop_front());
            end
        end
    end

    // Monitor B: same checks on the narrow-count instance.
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst_n && b_out_valid) begin
            cmp("b_in_ready_in_hold", {31'd0, b_in_ready}, 32'd0);
            if (q_b.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL b_unexpected_result: got max %0d, expected no result", b_out_max);
            end else begin
                e = q_b[0];
                cmp("b_max",     {16'd0, b_out_max},     e.mx);
                cmp("b_min",     {16'd0, b_out_min},     e.mn);
                cmp("b_max_idx", {30'd0, b_out_max_idx}, e.mxi);
                cmp("b_min_idx", {30'd0, b_out_min_idx}, e.mni);
                cmp("b_count",   {29'd0, b_out_count},   e.cnt);
                cmp("b_ovf",     {31'd0, b_out_ovf},     e.ovf);
                if (b_out_ready) void'(q_b.pop_front());
            end
        end
    end

    task automatic send_a(input logic [15:0] d, input logic last);
        int budget = 50;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (!in_ready) begin
            n_vec++; n_err++;
            $display("FAIL a_send_timeout: in_ready stayed 0, required 1");
        end
        @(posedge clk); #1;
    endtask

    task automatic send_b(input logic [15:0] d, input logic last);
        int budget = 50;
        b_in_valid = 1'b1;
        b_in_data  = d;
        b_in_last  = last;
        while (!b_in_ready && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (!b_in_ready) begin
            n_vec++; n_err++;
            $display("FAIL b_send_timeout: in_ready stayed 0, required 1");
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_a();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain(input string name);
        int budget = 50;
        while ((q_a.size() != 0 || q_b.size() != 0) && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL %s_drain_timeout: %0d results pending, required 0", name, q_a.size() + q_b.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 0; in_data = 0; in_last = 0; out_ready = 1;
        b_in_valid = 0; b_in_data = 0; b_in_last = 0; b_out_ready = 1;
        rst_n = 1'b0;
        #23 rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        cmp("rst_out_valid", {31'd0, out_valid}, 0);
        cmp("rst_in_ready",  {31'd0, in_ready},  1);
        cmp("rst_ovf",       {31'd0, out_ovf},   0);
        cmp("rst_max",       {16'd0, out_max},   0);
        cmp("rst_min",       {16'd0, out_min},   0);
        cmp("rst_max_idx",   {24'd0, out_max_idx}, 0);
        cmp("rst_min_idx",   {24'd0, out_min_idx}, 0);
        cmp("rst_count",     {23'd0, out_count}, 0);
        @(posedge clk); #1;

        // Single-sample frame
        q_a.push_back(mk(16'h1234, 16'h1234, 0, 0, 1, 0));
        send_a(16'h1234, 1'b1);
        cmp("single_latency_valid", {31'd0, out_valid}, 1);
        idle_a();
        drain("single");

        // Six-sample frame with ties, under backpressure
        out_ready = 1'b0;
        q_a.push_back(mk(16'hFFFF, 3, 1, 2, 6, 0));
        send_a(16'd5, 0);
        send_a(16'hFFFF, 0);
        send_a(16'd3, 0);
        send_a(16'hFFFF, 0);
        send_a(16'd3, 0);
        send_a(16'd7, 1);
        idle_a();
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk); #1;
        cmp("bp_release_out_valid", {31'd0, out_valid}, 0);
        cmp("bp_release_in_ready",  {31'd0, in_ready},  1);
        cmp("bp_popped", q_a.size(), 0);

        // Asynchronous reset during ACCUM
        send_a(16'd100, 0);
        send_a(16'd200, 0);
        send_a(16'd50, 0);
        idle_a();
        #3 rst_n = 1'b0;
        #1;
        cmp("midrst_out_valid", {31'd0, out_valid}, 0);
        cmp("midrst_count",     {23'd0, out_count}, 0);
        cmp("midrst_max",       {16'd0, out_max},   0);
        cmp("midrst_min",       {16'd0, out_min},   0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        q_a.push_back(mk(2, 1, 0, 1, 2, 0));
        send_a(16'd2, 0);
        send_a(16'd1, 1);
        idle_a();
        drain("after_reset");

        // Back-to-back frames with in_valid held high
        q_a.push_back(mk(20, 10, 1, 0, 2, 0));
        q_a.push_back(mk(30, 5, 0, 1, 2, 0));
        send_a(16'd10, 0);
        send_a(16'd20, 1);
        cmp("b2b_in_ready_drop", {31'd0, in_ready}, 0);
        send_a(16'd30, 0);
        send_a(16'd5, 1);
        idle_a();
        drain("b2b");

        // CNT_W=2: exactly 2^CNT_W samples, no overflow
        q_b.push_back(mk(3, 0, 2, 3, 4, 0));
        send_b(16'd1, 0);
        send_b(16'd2, 0);
        send_b(16'd3, 0);
        send_b(16'd0, 1);
        b_in_valid = 1'b0;
        drain("exact_fill");

        // CNT_W=2: six descending samples; count saturates, indices freeze
        q_b.push_back(mk(9, 4, 0, 3, 4, 1));
        send_b(16'd9, 0);
        send_b(16'd8, 0);
        send_b(16'd7, 0);
        send_b(16'd6, 0);
        send_b(16'd5, 0);
        send_b(16'd4, 1);
        b_in_valid = 1'b0;
        b_in_last  = 1'b0;
        drain("overflow");

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
